// File: rtl/mesh_port_arbiter.sv
// mesh_port_arbiter: round-robin arbiter with a one-word output buffer for one mesh router output port
module mesh_port_arbiter #(
    parameter int N_IN    = 5,
    parameter int pckg_sz = 40,
    parameter int IDX_W   = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN-1:0]         pndng_in,
    input  logic [N_IN*pckg_sz-1:0] data_in,
    output logic [N_IN-1:0]         pop,
    output logic                    pndng,
    output logic [pckg_sz-1:0]      data_out,
    input  logic                    popin,
    output logic [IDX_W-1:0]        last_grant,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] w, win, idx;
    logic             any, ok, found;

    assign any   = |pndng_in;
    assign ok    = pndng_in[w];
    assign pndng = state == HOLD;
    assign busy  = state != IDLE;
    // The grant register selects the pop line; gating with the request suppresses the pop of an aborted grant.
    assign pop   = state == GRANT ? pndng_in & (N_IN'(1) << w) : '0;

    // Round-robin search: first requester after last_grant, wrapping at N_IN-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = last_grant;
        for (int k = 0; k < N_IN; k++) begin
            idx = idx == IDX_W'(N_IN - 1) ? '0 : idx + 1'b1;
            if (!found && pndng_in[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state: GRANT lasts one cycle, HOLD waits for popin before re-arbitrating.
    always_comb begin
        state_n = state;
        state_n = state == IDLE  ? (any ? GRANT : IDLE) :
                  state == GRANT ? (ok ? HOLD : IDLE) :
                  popin          ? (any ? GRANT : IDLE) : HOLD;
    end

    // State, grant index, priority pointer and output buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            w          <= '0;
            last_grant <= IDX_W'(N_IN - 1);
            data_out   <= '0;
        end else begin
            state <= state_n;
            if (state_n == GRANT) w <= win;
            if (state == GRANT && ok) begin
                last_grant <= w;
                data_out   <= data_in[int'(w)*pckg_sz +: pckg_sz];
            end
        end
    end
endmodule
